rtc_alarm_clock: RTL
====================

Name: rtc_alarm_clock

Overview:
- Parametrised successor to the team's 24-hour BCD digital clock.
- Adds the following features:
  - run/pause control;
  - validated runtime time-set;
  - 12/24-hour display mode with a PM flag;
  - a programmable alarm with snooze and auto-stop.
- Sits between the system clock domain and the display/annunciator logic. All outputs are in the clk domain.

Parameters:
CNT_W, 32, width of the divider counter and of tick_div.
SNOOZE_MIN, 5, snooze length in minutes (1..60).
RING_MAX_S, 60, seconds of unacknowledged ringing before auto-stop (1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
tick_div  in  CNT_W  clk cycles per second; 0 is treated as 1
run  in  1  1 = time advances; 0 = divider and time frozen
mode_12h  in  1  1 = 12-hour display; 0 = 24-hour display
set_valid  in  1  load set_hh/set_mm/set_ss this cycle
set_hh/set_mm/set_ss  in  5/6/6  binary time to load
alarm_wr  in  1  load alarm_hh/alarm_mm this cycle
alarm_hh/alarm_mm  in  5/6  binary alarm time
alarm_en  in  1  alarm armed
alarm_ack  in  1  stop ringing or snooze
snooze  in  1  defer ringing by SNOOZE_MIN
sec_pulse  out  1  one-cycle pulse on each time advance
set_err  out  1  one-cycle pulse on a rejected set or alarm write
sec_ones/sec_tens/min_ones/min_tens/hour_ones/hour_tens  out  4 each  BCD display digits
pm  out  1  PM indicator
alarm_ring  out  1  alarm sounding

Behaviour:
- Reset (async, clk domain):
  - time 00:00:00, alarm 00:00, divider count 0, FSM IDLE.
  - sec_pulse=0, set_err=0, alarm_ring=0.
  - Digits follow time combinationally: all 0 in 24h mode; in 12h mode they read 12:00:00 with pm=0.
- Divider:
  - When run=1, cnt increments each clk.
  - Terminal condition is cnt >= max(tick_div,1)-1. The >= covers a tick_div decrease mid-count. On terminal, cnt<=0 and a tick occurs.
  - When run=0, cnt holds and no ticks occur.
- Time advance on tick:
  - Applied on the same edge that registers sec_pulse=1.
  - ss 59->0 carries to mm; mm 59->0 carries to hh; hh 23->0.
- set_valid:
  - Accepted iff hh<24, mm<60, ss<60. On accept: time loads next edge, cnt clears to 0, and a coincident tick is discarded (set wins, no sec_pulse).
  - On reject: set_err=1 for one cycle, time unchanged, tick proceeds normally.
  - Alarm state and the FSM are unaffected by set_valid.
- alarm_wr:
  - Accepted iff hh<24, mm<60; otherwise set_err pulses.
  - If set_valid and alarm_wr are both invalid in the same cycle, set_err is a single pulse.
- Display:
  - 24h mode: digits = BCD(hh), BCD(mm), BCD(ss); pm=0.
  - 12h mode: displayed hour = 12 if hh==0; hh-12 if hh>12; else hh. pm = (hh>=12).
- Alarm FSM (registered; all events evaluated on the tick edge against the next time value):
  - IDLE -> RING: tick where next time == alarm_hh:alarm_mm:00 and alarm_en=1. ring_cnt clears.
  - RING (alarm_ring=1):
    - alarm_ack=1 or alarm_en=0 -> IDLE.
    - Else snooze=1 -> SNOOZE, snz_cnt = SNOOZE_MIN*60.
    - Else on tick ring_cnt++; when ring_cnt reaches RING_MAX_S -> IDLE.
  - SNOOZE (alarm_ring=0):
    - alarm_ack=1 or alarm_en=0 -> IDLE.
    - On tick snz_cnt--; transition to 0 -> RING with ring_cnt cleared.
  - Alarm match in RING/SNOOZE is ignored.
  - Ack and snooze together: ack wins.
  - run=0 freezes ring_cnt and snz_cnt.
- Reset mid-operation: everything returns to reset values immediately (async); ringing stops.

Test Plan:
- Reset, tick_div=4, run=1, mode_12h=0 -> sec_pulse every 4th cycle; after 4 pulses sec_ones=4. Set run=0 for 20 cycles -> no pulses, digits hold.
- set_valid 23:59:58, two ticks -> 23:59:59 then 00:00:00. mode_12h=1 -> shows 12:00:00 pm=0. Set 13:05:00 -> shows 01:05:00 pm=1.
- set_valid hh=24 -> set_err high exactly 1 cycle, time unchanged. set_valid coincident with terminal count -> loaded value shown, no sec_pulse. tick_div=0 -> sec_pulse every cycle.
- alarm_wr 07:30, alarm_en=1, set 07:29:59, one tick -> alarm_ring=1 on the 07:30:00 edge. No ack for RING_MAX_S=60 ticks -> alarm_ring=0 at 07:31:00.
- In RING assert snooze -> alarm_ring=0; exactly 300 ticks later alarm_ring=1. Assert alarm_ack together with snooze -> IDLE; no re-ring.
- Assert reset while ringing at 07:30:10 -> alarm_ring=0, time 00:00:00, alarm 00:00, set_err=0.

Source files
------------

// File: rtl/rtc_alarm_clock.sv
// Real-time clock with run/pause, validated time set, 12/24-hour BCD display
// and an alarm that supports snooze and automatic stop after a ring timeout.
module rtc_alarm_clock #(
    parameter int CNT_W      = 32,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MAX_S = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] tick_div,
    input  logic             run,
    input  logic             mode_12h,
    input  logic             set_valid,
    input  logic [4:0]       set_hh,
    input  logic [5:0]       set_mm,
    input  logic [5:0]       set_ss,
    input  logic             alarm_wr,
    input  logic [4:0]       alarm_hh,
    input  logic [5:0]       alarm_mm,
    input  logic             alarm_en,
    input  logic             alarm_ack,
    input  logic             snooze,
    output logic             sec_pulse,
    output logic             set_err,
    output logic [3:0]       sec_ones,
    output logic [3:0]       sec_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       min_tens,
    output logic [3:0]       hour_ones,
    output logic [3:0]       hour_tens,
    output logic             pm,
    output logic             alarm_ring
);

    localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD   = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [7:0]       RING_LIMIT = 8'(RING_MAX_S);

    typedef enum logic [1:0] {IDLE, RING, SNZ} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, div_last;
    logic [4:0]       hh_reg, hh_next, inc_hh, al_hh_reg, al_hh_next;
    logic [5:0]       mm_reg, mm_next, inc_mm, al_mm_reg, al_mm_next;
    logic [5:0]       ss_reg, ss_next, inc_ss;
    logic [7:0]       ring_cnt_reg, ring_cnt_next;
    logic [SNZ_W-1:0] snz_cnt_reg, snz_cnt_next;
    logic             sec_pulse_reg, set_err_reg;
    logic             tick, adv, set_ok, alarm_ok, alarm_hit;
    logic [4:0]       disp_hh;
    logic [5:0]       field [3];
    logic [7:0]       bcd [3];

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] o;
        t = v / 6'd10;
        o = v - t * 6'd10;
        return {t[3:0], o[3:0]};
    endfunction

    // A zero divisor behaves as one: a tick on every enabled cycle.
    assign div_last = (tick_div == '0) ? '0 : tick_div - CNT_W'(1);
    assign tick     = run && (cnt_reg >= div_last);
    assign set_ok   = set_valid && (set_hh < 5'd24) && (set_mm < 6'd60) && (set_ss < 6'd60);
    assign alarm_ok = (alarm_hh < 5'd24) && (alarm_mm < 6'd60);
    assign adv      = tick && !set_ok;

    always_comb begin
        cnt_next = cnt_reg;
        if (set_ok || tick)
            cnt_next = '0;
        else if (run)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_comb begin
        inc_ss = ss_reg + 6'd1;
        inc_mm = mm_reg;
        inc_hh = hh_reg;
        if (ss_reg == 6'd59) begin
            inc_ss = '0;
            inc_mm = mm_reg + 6'd1;
            if (mm_reg == 6'd59) begin
                inc_mm = '0;
                inc_hh = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
            end
        end
    end

    always_comb begin
        hh_next    = hh_reg;
        mm_next    = mm_reg;
        ss_next    = ss_reg;
        al_hh_next = al_hh_reg;
        al_mm_next = al_mm_reg;
        if (set_ok) begin
            hh_next = set_hh;
            mm_next = set_mm;
            ss_next = set_ss;
        end else if (adv) begin
            hh_next = inc_hh;
            mm_next = inc_mm;
            ss_next = inc_ss;
        end
        if (alarm_wr && alarm_ok) begin
            al_hh_next = alarm_hh;
            al_mm_next = alarm_mm;
        end
    end

    // Alarm match looks at the time the current tick is about to produce.
    assign alarm_hit = alarm_en && (inc_hh == al_hh_reg) && (inc_mm == al_mm_reg) && (inc_ss == 6'd0);

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        snz_cnt_next  = snz_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (adv && alarm_hit) begin
                    state_next    = RING;
                    ring_cnt_next = '0;
                end
            end
            RING: begin
                if (alarm_ack || !alarm_en) begin
                    state_next = IDLE;
                end else if (snooze) begin
                    state_next   = SNZ;
                    snz_cnt_next = SNZ_LOAD;
                end else if (adv) begin
                    ring_cnt_next = ring_cnt_reg + 8'd1;
                    if (ring_cnt_reg + 8'd1 == RING_LIMIT)
                        state_next = IDLE;
                end
            end
            SNZ: begin
                if (alarm_ack || !alarm_en) begin
                    state_next = IDLE;
                end else if (adv) begin
                    snz_cnt_next = snz_cnt_reg - SNZ_W'(1);
                    if (snz_cnt_reg == SNZ_W'(1)) begin
                        state_next    = RING;
                        ring_cnt_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hh_reg        <= '0;
            mm_reg        <= '0;
            ss_reg        <= '0;
            al_hh_reg     <= '0;
            al_mm_reg     <= '0;
            ring_cnt_reg  <= '0;
            snz_cnt_reg   <= '0;
            sec_pulse_reg <= 1'b0;
            set_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hh_reg        <= hh_next;
            mm_reg        <= mm_next;
            ss_reg        <= ss_next;
            al_hh_reg     <= al_hh_next;
            al_mm_reg     <= al_mm_next;
            ring_cnt_reg  <= ring_cnt_next;
            snz_cnt_reg   <= snz_cnt_next;
            sec_pulse_reg <= adv;
            set_err_reg   <= (set_valid && !set_ok) || (alarm_wr && !alarm_ok);
        end
    end

    always_comb begin
        disp_hh = hh_reg;
        if (mode_12h) begin
            if (hh_reg == 5'd0)
                disp_hh = 5'd12;
            else if (hh_reg > 5'd12)
                disp_hh = hh_reg - 5'd12;
        end
    end

    assign field[0] = ss_reg;
    assign field[1] = mm_reg;
    assign field[2] = {1'b0, disp_hh};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
            assign bcd[gi] = to_bcd(field[gi]);
        end
    endgenerate

    assign sec_ones   = bcd[0][3:0];
    assign sec_tens   = bcd[0][7:4];
    assign min_ones   = bcd[1][3:0];
    assign min_tens   = bcd[1][7:4];
    assign hour_ones  = bcd[2][3:0];
    assign hour_tens  = bcd[2][7:4];
    assign pm         = mode_12h && (hh_reg >= 5'd12);
    assign sec_pulse  = sec_pulse_reg;
    assign set_err    = set_err_reg;
    assign alarm_ring = (state_reg == RING);

endmodule
